// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: the FSM state
// encoding, the default reset-vector address and the 6502 instruction
// length table, which the decoder and disassembler also use.
package ifetch_pkg;

  localparam logic [15:0] RST_VEC_DEF = 16'hFFFC;

  typedef enum logic [2:0] {
    VEC_LO,
    VEC_HI,
    VEC_JMP,
    OPC,
    OP1,
    OP2,
    OP3,
    HOLD
  } state_t;

  // Byte length (1..3) of a 6502 instruction given its opcode.
  // Undocumented opcodes are treated as single-byte.
  function automatic logic [1:0] insn_len_of(input logic [7:0] opcode);
    logic [1:0] len;
    len = 2'd1;
    case (opcode[3:0])
      4'h0: begin
        if (opcode == 8'h20)
          len = 2'd3;                              // JSR abs
        else if (opcode[4] || (opcode[7:4] >= 4'hA))
          len = 2'd2;                              // branches, LDY/CPY/CPX #
      end
      4'h1, 4'h5, 4'h6: len = 2'd2;                // (zp,X), (zp),Y, zp, zp,X/Y
      4'h2: if (opcode == 8'hA2) len = 2'd2;       // LDX #
      4'h4: if (opcode inside {8'h24, 8'h84, 8'h94, 8'hA4, 8'hB4, 8'hC4, 8'hE4})
              len = 2'd2;
      4'h9: begin
        if (opcode[4])
          len = 2'd3;                              // abs,Y
        else if (opcode != 8'h89)
          len = 2'd2;                              // immediate
      end
      4'hC: if (opcode inside {8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hBC, 8'hCC, 8'hEC})
              len = 2'd3;
      4'hD: len = 2'd3;                            // abs, abs,X
      4'hE: if (opcode != 8'h9E) len = 2'd3;
      default: len = 2'd1;                         // implied/accumulator/unused
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch sequencer. Loads the reset vector, then reads opcode
// and operand bytes at the PC (advancing it per byte) and presents each
// assembled instruction to the decoder over a valid/ready handshake.
// Execute-stage redirects restart fetch at a new address.
//
// state   | meaning
// --------+-------------------------------------------------------------
// VEC_LO  | read low byte of reset vector
// VEC_HI  | capture low byte, read high byte
// VEC_JMP | branch PC to the assembled vector
// OPC     | read opcode at PC, latch its address
// OP1     | capture opcode; read first operand if length >= 2
// OP2     | capture first operand; read second operand if length == 3
// OP3     | capture second operand
// HOLD    | bundle valid, waiting for the decoder
module ifetch
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] RST_VEC = ADDR_W'(RST_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              increment,
  output logic              branch,
  output logic [ADDR_W-1:0] bra_add,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [DATA_W-1:0] insn_opcode,
  output logic [DATA_W-1:0] insn_op1,
  output logic [DATA_W-1:0] insn_op2,
  output logic [1:0]        insn_len,
  output logic [ADDR_W-1:0] insn_pc
);

  state_t            st;
  logic [DATA_W-1:0] vec_lo;
  logic [DATA_W-1:0] opc_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [1:0]        len_q;
  logic [ADDR_W-1:0] pc_q;

  logic              take_redir;
  logic [1:0]        len_now;

  // Redirect only counts once the vector load is done; length of the
  // opcode arriving on the read bus this cycle.
  always_comb begin
    take_redir = !rst && redirect &&
                 (st inside {OPC, OP1, OP2, OP3, HOLD});
    len_now    = insn_len_of(mem_rdata);
  end

  // PC/memory controls are combinational so a redirect acts in the same cycle.
  always_comb begin
    mem_rd     = 1'b0;
    mem_addr   = pc_addr;
    increment  = 1'b0;
    branch     = 1'b0;
    bra_add    = '0;
    insn_valid = 1'b0;
    if (rst) begin
      mem_addr = '0;
    end else if (take_redir) begin
      branch  = 1'b1;
      bra_add = redirect_addr;
    end else begin
      case (st)
        VEC_LO: begin
          mem_rd   = 1'b1;
          mem_addr = RST_VEC;
        end
        VEC_HI: begin
          mem_rd   = 1'b1;
          mem_addr = RST_VEC + ADDR_W'(1);
        end
        VEC_JMP: begin
          branch  = 1'b1;
          bra_add = {mem_rdata, vec_lo};
        end
        OPC: begin
          mem_rd    = 1'b1;
          increment = 1'b1;
        end
        OP1: begin
          if (len_now != 2'd1) begin
            mem_rd    = 1'b1;
            increment = 1'b1;
          end
        end
        OP2: begin
          if (len_q == 2'd3) begin
            mem_rd    = 1'b1;
            increment = 1'b1;
          end
        end
        HOLD:    insn_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // State sequencing and byte capture into the instruction bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= VEC_LO;
      vec_lo <= '0;
      opc_q  <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      len_q  <= '0;
      pc_q   <= '0;
    end else if (take_redir) begin
      // Drop any partially assembled instruction.
      st    <= OPC;
      opc_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      len_q <= '0;
    end else begin
      case (st)
        VEC_LO: st <= VEC_HI;
        VEC_HI: begin
          vec_lo <= mem_rdata;
          st     <= VEC_JMP;
        end
        VEC_JMP: st <= OPC;
        OPC: begin
          pc_q  <= pc_addr;
          op1_q <= '0;
          op2_q <= '0;
          st    <= OP1;
        end
        OP1: begin
          opc_q <= mem_rdata;
          len_q <= len_now;
          st    <= (len_now == 2'd1) ? HOLD : OP2;
        end
        OP2: begin
          op1_q <= mem_rdata;
          st    <= (len_q == 2'd3) ? OP3 : HOLD;
        end
        OP3: begin
          op2_q <= mem_rdata;
          st    <= HOLD;
        end
        HOLD: if (insn_ready) st <= OPC;
        default: st <= VEC_LO;
      endcase
    end
  end

  assign insn_opcode = opc_q;
  assign insn_op1    = op1_q;
  assign insn_op2    = op2_q;
  assign insn_len    = len_q;
  assign insn_pc     = pc_q;

endmodule
